// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the I/D main-memory port arbiter.
// Latency: none (types and pure functions only).
// Backpressure: n/a.
package mem_arb_pkg;

  localparam int MEM_BYTES = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT,
    ARB_DONE
  } arb_state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_e;

  // Byte lanes: element [0] carries word[31:24] down to element [3] = word[7:0].
  typedef logic [0:MEM_BYTES-1][7:0] mem_bytes_t;

  function automatic mem_bytes_t word_to_bytes(input logic [31:0] w);
    mem_bytes_t r;
    for (int b = 0; b < MEM_BYTES; b++) begin
      r[b] = w[31-8*b -: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] bytes_to_word(input mem_bytes_t by);
    logic [31:0] w;
    for (int b = 0; b < MEM_BYTES; b++) begin
      w[31-8*b -: 8] = by[b];
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin chooser: picks I or D, alternating when both ask.
// Latency: purely combinational.
// Backpressure: none; caller decides when the pick is consumed.
import mem_arb_pkg::*;

module rr_pick2 (
  input  logic [1:0] req,    // [0] = I side, [1] = D side
  input  owner_e     last,
  output owner_e     grant
);

  // Single requester wins outright; a tie goes to whoever did not win last.
  always_comb begin
    grant = OWN_I;
    case (req)
      2'b01:   grant = OWN_I;
      2'b10:   grant = OWN_D;
      2'b11:   grant = (last == OWN_D) ? OWN_I : OWN_D;
      default: grant = OWN_I;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-lane memory port between I-cache reads and D-cache reads/writes.
// Latency: request sampled at edge E, done pulses after edge E+MEM_LATENCY, next accept at E+MEM_LATENCY+2.
// Backpressure: requests are held by the caller; any request seen while busy simply waits for IDLE.
// Optional ARB_PERF_EN macro adds grant/conflict counters as extra output ports.
import mem_arb_pkg::*;

module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int MEM_LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output mem_bytes_t        mem_data_in,
  input  mem_bytes_t        mem_data_out,
`ifdef ARB_PERF_EN
  output logic [31:0]       i_grant_cnt,
  output logic [31:0]       d_grant_cnt,
  output logic [31:0]       conflict_cnt,
`endif
  output logic              busy
);

  // Counter is loaded with MEM_LATENCY-1 so the capture edge lands exactly MEM_LATENCY edges after issue.
  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_grant_q, last_grant_d;
  logic              owner_we_q, owner_we_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  mem_bytes_t        mem_data_in_q, mem_data_in_d;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  owner_e            grant;

`ifdef ARB_PERF_EN
  logic [31:0]       i_grant_cnt_q, i_grant_cnt_d;
  logic [31:0]       d_grant_cnt_q, d_grant_cnt_d;
  logic [31:0]       conflict_cnt_q, conflict_cnt_d;
`endif

  rr_pick2 u_pick (
    .req   ({d_req, i_req}),
    .last  (last_grant_q),
    .grant (grant)
  );

  // Next-state and output logic; every register holds unless its state says otherwise.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    owner_we_d    = owner_we_q;
    cnt_d         = cnt_q;
    mem_addr_d    = mem_addr_q;
    mem_we_d      = mem_we_q;
    mem_data_in_d = mem_data_in_q;
    i_rdata_d     = i_rdata_q;
    d_rdata_d     = d_rdata_q;
    i_done_d      = i_done_q;
    d_done_d      = d_done_q;
`ifdef ARB_PERF_EN
    i_grant_cnt_d  = i_grant_cnt_q;
    d_grant_cnt_d  = d_grant_cnt_q;
    conflict_cnt_d = conflict_cnt_q;
`endif

    case (state_q)
      ARB_IDLE: begin
        if (i_req || d_req) begin
          owner_d      = grant;
          last_grant_d = grant;
          cnt_d        = CNT_INIT;
          state_d      = ARB_WAIT;
          if (grant == OWN_D) begin
            owner_we_d    = d_we;
            mem_we_d      = d_we;
            mem_addr_d    = d_addr;
            mem_data_in_d = word_to_bytes(d_wdata);
          end else begin
            // I side never writes; its data lanes carry nothing.
            owner_we_d    = 1'b0;
            mem_we_d      = 1'b0;
            mem_addr_d    = i_addr;
            mem_data_in_d = word_to_bytes(32'h0);
          end
`ifdef ARB_PERF_EN
          if (grant == OWN_D) d_grant_cnt_d = d_grant_cnt_q + 32'd1;
          else                i_grant_cnt_d = i_grant_cnt_q + 32'd1;
          if (i_req && d_req) conflict_cnt_d = conflict_cnt_q + 32'd1;
`endif
        end
      end

      ARB_WAIT: begin
        // Write strobe lasts only the issue cycle.
        mem_we_d = 1'b0;
        if (cnt_q == 4'd0) begin
          state_d = ARB_DONE;
          if (owner_q == OWN_I) begin
            i_done_d  = 1'b1;
            i_rdata_d = bytes_to_word(mem_data_out);
          end else begin
            d_done_d = 1'b1;
            if (!owner_we_q) d_rdata_d = bytes_to_word(mem_data_out);
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ARB_DONE: begin
        i_done_d = 1'b0;
        d_done_d = 1'b0;
        state_d  = ARB_IDLE;
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction without a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ARB_IDLE;
      owner_q       <= OWN_I;
      last_grant_q  <= OWN_D;
      owner_we_q    <= 1'b0;
      cnt_q         <= 4'd0;
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_data_in_q <= '0;
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
      i_done_q      <= 1'b0;
      d_done_q      <= 1'b0;
`ifdef ARB_PERF_EN
      i_grant_cnt_q  <= '0;
      d_grant_cnt_q  <= '0;
      conflict_cnt_q <= '0;
`endif
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      owner_we_q    <= owner_we_d;
      cnt_q         <= cnt_d;
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_data_in_q <= mem_data_in_d;
      i_rdata_q     <= i_rdata_d;
      d_rdata_q     <= d_rdata_d;
      i_done_q      <= i_done_d;
      d_done_q      <= d_done_d;
`ifdef ARB_PERF_EN
      i_grant_cnt_q  <= i_grant_cnt_d;
      d_grant_cnt_q  <= d_grant_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
`endif
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_data_in = mem_data_in_q;
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign i_done      = i_done_q;
  assign d_done      = d_done_q;
  assign busy        = (state_q != ARB_IDLE);
`ifdef ARB_PERF_EN
  assign i_grant_cnt  = i_grant_cnt_q;
  assign d_grant_cnt  = d_grant_cnt_q;
  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a tiny address-decoded memory model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W = 32;
  localparam int LAT    = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_req, d_req, d_we;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [31:0]       d_wdata;
  logic [31:0]       i_rdata, d_rdata;
  logic              i_done, d_done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  mem_bytes_t        mem_data_in, mem_data_out;
  logic              busy;
`ifdef ARB_PERF_EN
  logic [31:0]       i_grant_cnt, d_grant_cnt, conflict_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .MEM_LATENCY(LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_req        (i_req),
    .i_addr       (i_addr),
    .i_rdata      (i_rdata),
    .i_done       (i_done),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_done       (d_done),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
`ifdef ARB_PERF_EN
    .i_grant_cnt  (i_grant_cnt),
    .d_grant_cnt  (d_grant_cnt),
    .conflict_cnt (conflict_cnt),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Memory model: 0x100 holds DEADBEEF, every other word reads C0DE_<addr[15:0]>.
  always_comb begin
    if (mem_addr == 32'h100) mem_data_out = 32'hDEADBEEF;
    else                     mem_data_out = {16'hC0DE, mem_addr[15:0]};
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Ticks until a done pulse shows or 20 edges elapse; n counts edges taken.
  task automatic wait_done(output logic gi, output logic gd, output int n);
    n = 0;
    while (!(i_done || d_done) && n < 20) begin
      tick();
      n++;
    end
    gi = i_done;
    gd = d_done;
  endtask

  task automatic do_reset;
    reset = 1'b1; i_req = 0; d_req = 0; d_we = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    do_reset();
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (mem_we !== 1'b0)     begin n_bad++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    n_cmp++; if (mem_addr !== 32'h0)  begin n_bad++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    n_cmp++; if ({i_done, d_done} !== 2'b00) begin n_bad++; $display("FAIL reset_done got %b want 00", {i_done, d_done}); end
    n_cmp++; if ({i_rdata, d_rdata} !== 64'h0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", {i_rdata, d_rdata}); end
    n_cmp++; if (mem_data_in !== 32'h0) begin n_bad++; $display("FAIL reset_mem_data_in got %h want 0", mem_data_in); end
  endtask

  task automatic test_i_read;
    i_req = 1'b1; i_addr = 32'h100;
    tick();  // issue edge E
    n_cmp++; if (busy !== 1'b1)        begin n_bad++; $display("FAIL iread_busy got %b want 1", busy); end
    n_cmp++; if (mem_addr !== 32'h100) begin n_bad++; $display("FAIL iread_addr got %h want 100", mem_addr); end
    n_cmp++; if (mem_we !== 1'b0)      begin n_bad++; $display("FAIL iread_we got %b want 0", mem_we); end
    for (int k = 1; k < LAT; k++) begin
      tick();
      n_cmp++; if (i_done !== 1'b0) begin n_bad++; $display("FAIL iread_early_done edge %0d got %b want 0", k, i_done); end
    end
    tick();  // E+LAT
    n_cmp++; if (i_done !== 1'b1)          begin n_bad++; $display("FAIL iread_done got %b want 1", i_done); end
    n_cmp++; if (i_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL iread_rdata got %h want deadbeef", i_rdata); end
    n_cmp++; if ({d_done, d_rdata} !== 33'h0) begin n_bad++; $display("FAIL iread_d_side got %b/%h want 0/0", d_done, d_rdata); end
    i_req = 1'b0;
    tick();
    n_cmp++; if ({i_done, busy} !== 2'b00) begin n_bad++; $display("FAIL iread_after got %b want 00", {i_done, busy}); end
  endtask

  task automatic test_d_write;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h11223344;
    tick();
    n_cmp++; if (mem_we !== 1'b1)            begin n_bad++; $display("FAIL dwr_we_issue got %b want 1", mem_we); end
    n_cmp++; if (mem_addr !== 32'h200)       begin n_bad++; $display("FAIL dwr_addr got %h want 200", mem_addr); end
    n_cmp++; if (mem_data_in[0] !== 8'h11 || mem_data_in[3] !== 8'h44 || mem_data_in !== 32'h11223344)
      begin n_bad++; $display("FAIL dwr_bytes got %h want 11223344", mem_data_in); end
    tick();
    n_cmp++; if (mem_we !== 1'b0)            begin n_bad++; $display("FAIL dwr_we_wait got %b want 0", mem_we); end
    for (int k = 2; k <= LAT; k++) tick();
    n_cmp++; if (d_done !== 1'b1)            begin n_bad++; $display("FAIL dwr_done got %b want 1", d_done); end
    n_cmp++; if (d_rdata !== 32'h0)          begin n_bad++; $display("FAIL dwr_rdata got %h want 0", d_rdata); end
    n_cmp++; if (i_rdata !== 32'hDEADBEEF)   begin n_bad++; $display("FAIL dwr_i_untouched got %h want deadbeef", i_rdata); end
    d_req = 1'b0; d_we = 1'b0;
    tick();
    n_cmp++; if (d_done !== 1'b0)            begin n_bad++; $display("FAIL dwr_done_pulse got %b want 0", d_done); end
  endtask

  task automatic test_alternation;
    logic gi, gd;
    int   n;
    logic exp_i;
    do_reset();
    i_addr = 32'h300; d_addr = 32'h400; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_i = (k % 2 == 0);
      wait_done(gi, gd, n);
      n_cmp++; if ({gi, gd} !== {exp_i, ~exp_i}) begin n_bad++; $display("FAIL alt_owner #%0d got i%b d%b want i%b", k, gi, gd, exp_i); end
      n_cmp++; if (n !== LAT + 1) begin n_bad++; $display("FAIL alt_spacing #%0d got %0d want %0d", k, n, LAT + 1); end
      if (exp_i) begin
        n_cmp++; if (i_rdata !== 32'hC0DE0300) begin n_bad++; $display("FAIL alt_i_rdata got %h want c0de0300", i_rdata); end
      end else begin
        n_cmp++; if (d_rdata !== 32'hC0DE0400) begin n_bad++; $display("FAIL alt_d_rdata got %h want c0de0400", d_rdata); end
      end
      tick();
    end
    i_req = 1'b0; d_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_back_to_back;
    logic gi, gd;
    int   n;
    i_req = 1'b1; i_addr = 32'h600;
    tick();  // E: I granted
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700;
    for (int k = 1; k <= LAT; k++) tick();
    n_cmp++; if (i_done !== 1'b1) begin n_bad++; $display("FAIL b2b_i_done got %b want 1", i_done); end
    i_req = 1'b0;
    tick();  // E+LAT+1: back in IDLE
    n_cmp++; if (mem_addr !== 32'h600 || busy !== 1'b0) begin n_bad++; $display("FAIL b2b_hold got %h/%b want 600/0", mem_addr, busy); end
    tick();  // E+LAT+2: D granted
    n_cmp++; if (mem_addr !== 32'h700 || busy !== 1'b1) begin n_bad++; $display("FAIL b2b_d_grant got %h/%b want 700/1", mem_addr, busy); end
    wait_done(gi, gd, n);
    n_cmp++; if (gd !== 1'b1 || n !== LAT) begin n_bad++; $display("FAIL b2b_d_done got d%b after %0d want d1 after %0d", gd, n, LAT); end
    n_cmp++; if (d_rdata !== 32'hC0DE0700) begin n_bad++; $display("FAIL b2b_d_rdata got %h want c0de0700", d_rdata); end
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_wait;
    logic gi, gd;
    int   n;
    logic seen;
    i_req = 1'b1; i_addr = 32'h100;
    tick(); tick();  // now in WAIT
    i_req = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({busy, mem_we, i_done, d_done} !== 4'b0000) begin n_bad++; $display("FAIL rstw_ctrl got %b want 0000", {busy, mem_we, i_done, d_done}); end
    n_cmp++; if (mem_addr !== 32'h0 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin n_bad++; $display("FAIL rstw_data got %h/%h/%h want 0", mem_addr, i_rdata, d_rdata); end
    tick();
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < LAT + 3; k++) begin
      tick();
      if (i_done || d_done) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rstw_no_done got %b want 0", seen); end
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    wait_done(gi, gd, n);
    n_cmp++; if (gd !== 1'b1 || n !== LAT + 1) begin n_bad++; $display("FAIL rstw_next got d%b after %0d want d1 after %0d", gd, n, LAT + 1); end
    n_cmp++; if (d_rdata !== 32'hC0DE0500) begin n_bad++; $display("FAIL rstw_next_rdata got %h want c0de0500", d_rdata); end
    d_req = 1'b0;
    tick();
  endtask

`ifdef ARB_PERF_EN
  task automatic test_perf;
    logic gi, gd;
    int   n;
    do_reset();
    i_addr = 32'h800; d_addr = 32'h900; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_done(gi, gd, n);
      if (k < 2) tick();
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();
    for (int k = 0; k < 6; k++) begin
      if (k < 3) i_req = 1'b1; else d_req = 1'b1;
      wait_done(gi, gd, n);
      i_req = 1'b0; d_req = 1'b0;
      tick();
    end
    n_cmp++; if (conflict_cnt !== 32'd3) begin n_bad++; $display("FAIL perf_conflict got %0d want 3", conflict_cnt); end
    n_cmp++; if (i_grant_cnt !== 32'd5)  begin n_bad++; $display("FAIL perf_i_grants got %0d want 5", i_grant_cnt); end
    n_cmp++; if (d_grant_cnt !== 32'd4)  begin n_bad++; $display("FAIL perf_d_grants got %0d want 4", d_grant_cnt); end
    do_reset();
    n_cmp++; if ({conflict_cnt, i_grant_cnt, d_grant_cnt} !== 96'h0) begin n_bad++; $display("FAIL perf_reset got %0d/%0d/%0d want 0", conflict_cnt, i_grant_cnt, d_grant_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_alternation();
    test_back_to_back();
    test_reset_mid_wait();
`ifdef ARB_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
